// File: rtl/alu_exec_stage.sv
// Execute-stage ALU feeding the EX/MEM register: registered result with zero/overflow/illegal
// flags, stall/flush control and a saturating count of retired legal operations.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_overflow;
    logic             w_illegal;
    logic             w_slt;
    logic             w_load;
    logic             w_cnt_inc;

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    assign w_sum  = src_a + src_b;
    assign w_diff = src_a - src_b;
    assign w_slt  = $signed(src_a) < $signed(src_b);

    // Codes holding X/Z match no item and therefore land in the illegal default.
    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        w_illegal  = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin
                w_result   = w_sum;
                w_overflow = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_result   = w_diff;
                w_overflow = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND:  w_result = src_a & src_b;
            OP_OR:   w_result = src_a | src_b;
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_slt};
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_load    = !flush && !stall;
    assign w_cnt_inc = w_load && in_valid && !w_illegal && !(&r_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (!stall) begin
                r_valid <= in_valid;
            end
            if (w_load && in_valid) begin
                r_result   <= w_result;
                r_zero     <= (w_result == '0);
                r_overflow <= w_overflow;
                r_illegal  <= w_illegal;
            end
            if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out_valid   = r_valid;
    assign alu_result  = r_result;
    assign zero        = r_zero;
    assign overflow    = r_overflow;
    assign illegal     = r_illegal;
    assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: stimulus pushes the expected register state per cycle,
// a monitor pops and compares one cycle later; a CNT_W=2 copy covers counter saturation.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, flush;
    logic [2:0]  alu_ctrl;
    logic [31:0] src_a, src_b;

    logic        out_valid, zero, overflow, illegal;
    logic [31:0] alu_result;
    logic [15:0] retired_cnt;

    logic        out_valid2, zero2, overflow2, illegal2;
    logic [31:0] alu_result2;
    logic [1:0]  retired_cnt2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic [31:0] r;
        logic        z, o, i;
        logic [15:0] c;
        logic [1:0]  c2;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];
    exp_t st;

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .alu_result(alu_result), .zero(zero),
        .overflow(overflow), .illegal(illegal), .retired_cnt(retired_cnt)
    );

    alu_exec_stage #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid2), .alu_result(alu_result2), .zero(zero2),
        .overflow(overflow2), .illegal(illegal2), .retired_cnt(retired_cnt2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus driven at the falling edge; er/ez/eo/ei are the hand-computed
    // results for the presented operation.
    task automatic cyc(input bit inv, input bit stl, input bit fl, input logic [2:0] ctrl,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                       input bit ez, input bit eo, input bit ei);
        @(negedge clk);
        in_valid = inv; stall = stl; flush = fl; alu_ctrl = ctrl; src_a = a; src_b = b;
        if (fl) begin
            st.v = 1'b0;
        end else if (!stl) begin
            st.v = inv;
            if (inv) begin
                st.r = er; st.z = ez; st.o = eo; st.i = ei;
                if (!ei && st.c != 16'hFFFF) st.c = st.c + 16'd1;
                if (!ei && st.c2 != 2'd3) st.c2 = st.c2 + 2'd1;
            end
        end
        st.chk_data = st.v || fl;
        sb.push_back(st);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_valid", 64'(out_valid), 64'(e.v));
                chk("retired_cnt", 64'(retired_cnt), 64'(e.c));
                chk("retired_cnt_sat", 64'(retired_cnt2), 64'(e.c2));
                if (e.chk_data) begin
                    chk("alu_result", 64'(alu_result), 64'(e.r));
                    chk("zero", 64'(zero), 64'(e.z));
                    chk("overflow", 64'(overflow), 64'(e.o));
                    chk("illegal", 64'(illegal), 64'(e.i));
                end
                $display("cycle t=%0t v=%0b res=0x%08h z=%0b o=%0b i=%0b cnt=%0d cnt_sat=%0d",
                         $time, out_valid, alu_result, zero, overflow, illegal,
                         retired_cnt, retired_cnt2);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_alu_result"}, 64'(alu_result), 64'd0);
        chk({tag, "_zero"}, 64'(zero), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_illegal"}, 64'(illegal), 64'd0);
        chk({tag, "_retired_cnt"}, 64'(retired_cnt), 64'd0);
        chk({tag, "_retired_cnt_sat"}, 64'(retired_cnt2), 64'd0);
    endtask

    initial begin
        st = '{v: 1'b0, r: 32'd0, z: 1'b0, o: 1'b0, i: 1'b0, c: 16'd0, c2: 2'd0, chk_data: 1'b0};
        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        alu_ctrl = 3'b000; src_a = '0; src_b = '0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // basic operations (saturating copy counts 1,2,3,3,3)
        cyc(1, 0, 0, 3'b010, 32'd5, 32'd7, 32'd12, 0, 0, 0);
        cyc(1, 0, 0, 3'b110, 32'd7, 32'd7, 32'd0, 1, 0, 0);
        cyc(1, 0, 0, 3'b000, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 0, 0, 0);
        cyc(1, 0, 0, 3'b001, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 0, 0, 0);
        cyc(1, 0, 0, 3'b111, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0);
        // overflow cases
        cyc(1, 0, 0, 3'b010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 1, 0);
        cyc(1, 0, 0, 3'b110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 1, 0);
        cyc(1, 0, 0, 3'b010, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0, 0);
        // illegal code
        cyc(1, 0, 0, 3'b100, 32'd3, 32'd4, 32'd0, 1, 0, 1);
        // stall and flush
        cyc(1, 0, 0, 3'b010, 32'd1, 32'd2, 32'd3, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(1, 1, 0, 3'b110, 32'd9, 32'd4, 32'd5, 0, 0, 0);
        cyc(1, 1, 1, 3'b110, 32'd9, 32'd4, 32'd5, 0, 0, 0);
        cyc(1, 0, 0, 3'b010, 32'd5, 32'd7, 32'd12, 0, 0, 0);

        // asynchronous reset mid-cycle while result 12 is valid
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        st = '{v: 1'b0, r: 32'd0, z: 1'b0, o: 1'b0, i: 1'b0, c: 16'd0, c2: 2'd0, chk_data: 1'b0};
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0, 3'b010, 32'd2, 32'd2, 32'd4, 0, 0, 0);
        cyc(0, 0, 0, 3'b000, 32'd0, 32'd0, 32'd0, 0, 0, 0);

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
